// File: rtl/mult_accum.sv
// Signed dot-product accumulator fed by the 4x4 multiplier: sums FrameLen
// products into a saturating ACC_W-bit register and hands the result downstream.
module mult_accum #(
  parameter int ACC_W = 12,
  parameter int LEN_W = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [LEN_W-1:0]  FrameLen,
  input  logic              InValid,
  output logic              InReady,
  input  logic signed [7:0] Product,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [ACC_W-1:0]  AccOut,
  output logic              Overflow,
  output logic              Busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a beat moves on a rising edge where valid & ready are both high.
  // The source holds valid/data until that edge; ready never depends on valid.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MAX_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state;
  logic [LEN_W-1:0] count;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_next;
  logic             sat;

  // One guard bit is enough: a single 8-bit product cannot move acc by more than one range.
  always_comb begin
    sum_ext  = {acc[ACC_W-1], acc} + {{(ACC_W-7){Product[7]}}, Product};
    sat      = 1'b0;
    acc_next = sum_ext[ACC_W-1:0];
    if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
      sat      = 1'b1;
      acc_next = sum_ext[ACC_W] ? MAX_NEG : MAX_POS;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= S_IDLE;
      count <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= FrameLen;
            state <= (FrameLen == '0) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (InValid) begin
            acc   <= acc_next;
            ovf   <= ovf | sat;
            count <= count - LEN_W'(1);
            if (count == LEN_W'(1)) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (OutReady) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign InReady   = (state == S_ACCUM);
  assign OutValid  = (state == S_DONE);
  assign Busy      = (state != S_IDLE);
  assign AccOut    = acc;
  assign Overflow  = ovf;
  assign dbg_state = state;

endmodule

// File: tb/tb_mult_accum.sv
// Directed bench for mult_accum: a 12-bit and an 8-bit accumulator share one
// stimulus stream so saturation and in-range behaviour are observed together.
module tb_mult_accum;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              Start = 1'b0;
  logic [3:0]        FrameLen = '0;
  logic              InValid = 1'b0;
  logic signed [7:0] Product = '0;
  logic              OutReady = 1'b0;

  logic              in_ready, out_valid, overflow, busy;
  logic [11:0]       acc_out;
  logic [1:0]        dbg_state;
  logic              in_ready8, out_valid8, overflow8, busy8;
  logic [7:0]        acc_out8;
  logic [1:0]        dbg_state8;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  always #5 Clk = ~Clk;

  mult_accum #(.ACC_W(12), .LEN_W(4)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .FrameLen(FrameLen),
    .InValid(InValid), .InReady(in_ready), .Product(Product),
    .OutValid(out_valid), .OutReady(OutReady), .AccOut(acc_out),
    .Overflow(overflow), .Busy(busy), .dbg_state(dbg_state)
  );

  mult_accum #(.ACC_W(8), .LEN_W(4)) u_dut8 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .FrameLen(FrameLen),
    .InValid(InValid), .InReady(in_ready8), .Product(Product),
    .OutValid(out_valid8), .OutReady(OutReady), .AccOut(acc_out8),
    .Overflow(overflow8), .Busy(busy8), .dbg_state(dbg_state8)
  );

  // driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [3:0] len);
    Start    = 1'b1;
    FrameLen = len;
    tick();
    Start    = 1'b0;
  endtask

  task automatic beat(input logic signed [7:0] p);
    InValid = 1'b1;
    Product = p;
    tick();
    InValid = 1'b0;
  endtask

  task automatic drain();
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    chk("drain_outvalid", out_valid, 0);
    chk("drain_busy", busy, 0);
  endtask

  int beats;

  initial begin
    // reset then idle
    repeat (3) tick();
    chk("rst_inready", in_ready, 0);
    chk("rst_outvalid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_accout", $signed(acc_out), 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_accout8", $signed(acc_out8), 0);
    Rst_n   = 1'b1;
    InValid = 1'b1;
    Product = 8'sd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_inready", in_ready, 0);
      chk("idle_busy", busy, 0);
    end
    chk("idle_accout", $signed(acc_out), 0);
    InValid = 1'b0;

    // basic frame 5, -3, 10 with output backpressure
    start_frame(4'd3);
    chk("basic_busy", busy, 1);
    chk("basic_inready", in_ready, 1);
    beat(8'sd5);
    chk("basic_b1_outvalid", out_valid, 0);
    beat(-8'sd3);
    chk("basic_b2_outvalid", out_valid, 0);
    beat(8'sd10);
    chk("basic_outvalid", out_valid, 1);
    chk("basic_inready_after", in_ready, 0);
    chk("basic_accout", $signed(acc_out), 12);
    chk("basic_overflow", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      InValid = 1'b1;
      Product = 8'sd99;
      tick();
      chk("hold_outvalid", out_valid, 1);
      chk("hold_accout", $signed(acc_out), 12);
    end
    InValid = 1'b0;
    drain();

    // max length with bubbles: fifteen 64s, InValid every other cycle
    start_frame(4'd15);
    beats = 0;
    Product = 8'sd64;
    for (int c = 0; c < 80 && !out_valid; c++) begin
      InValid = (c % 2 == 0);
      if (InValid && in_ready) beats++;
      tick();
    end
    InValid = 1'b0;
    chk("bub_outvalid", out_valid, 1);
    chk("bub_beats", beats, 15);
    chk("bub_accout", $signed(acc_out), 960);
    chk("bub_overflow", overflow, 0);
    chk("bub_accout8", $signed(acc_out8), 127);
    chk("bub_overflow8", overflow8, 1);
    drain();

    // positive saturation then recovery on the 8-bit instance
    start_frame(4'd3);
    chk("satp_ovf_cleared8", overflow8, 0);
    beat(8'sd64);
    beat(8'sd64);
    chk("satp_clamp8", $signed(acc_out8), 127);
    beat(-8'sd10);
    chk("satp_outvalid8", out_valid8, 1);
    chk("satp_accout8", $signed(acc_out8), 117);
    chk("satp_overflow8", overflow8, 1);
    chk("satp_accout", $signed(acc_out), 118);
    chk("satp_overflow", overflow, 0);
    drain();

    // negative saturation
    start_frame(4'd3);
    beat(-8'sd56);
    beat(-8'sd56);
    beat(-8'sd56);
    chk("satn_accout8", $signed(acc_out8), -128);
    chk("satn_overflow8", overflow8, 1);
    chk("satn_accout", $signed(acc_out), -168);
    chk("satn_overflow", overflow, 0);
    drain();

    // zero-length frame, Start ignored in DONE
    start_frame(4'd0);
    chk("zero_outvalid", out_valid, 1);
    chk("zero_inready", in_ready, 0);
    chk("zero_accout", $signed(acc_out), 0);
    chk("zero_overflow8", overflow8, 0);
    start_frame(4'd5);
    chk("zero_start_outvalid", out_valid, 1);
    chk("zero_start_accout", $signed(acc_out), 0);
    drain();

    // Start ignored in ACCUM: count must not reload to 7
    start_frame(4'd2);
    Start    = 1'b1;
    FrameLen = 4'd7;
    beat(8'sd3);
    Start    = 1'b0;
    beat(8'sd4);
    chk("acc_start_outvalid", out_valid, 1);
    chk("acc_start_accout", $signed(acc_out), 7);
    drain();

    // reset mid-frame discards the partial sum
    start_frame(4'd4);
    beat(8'sd9);
    beat(8'sd9);
    chk("mid_partial", $signed(acc_out), 18);
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    chk("mid_busy", busy, 0);
    chk("mid_inready", in_ready, 0);
    chk("mid_accout", $signed(acc_out), 0);
    for (int i = 0; i < 3; i++) begin
      InValid = 1'b1;
      Product = 8'sd9;
      tick();
      chk("mid_no_outvalid", out_valid, 0);
    end
    InValid = 1'b0;
    start_frame(4'd1);
    beat(-8'sd7);
    chk("post_outvalid", out_valid, 1);
    chk("post_accout", $signed(acc_out), -7);
    chk("post_accout8", $signed(acc_out8), -7);
    drain();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_accum.md
# mult_accum

Sequential signed accumulator directly downstream of the 4x4 Baugh-Wooley multiplier. Consumes the multiplier's 8-bit two's-complement product one beat at a time over a valid/ready handshake, sums a programmed number of products (a dot-product frame), and presents the saturated sum on an output valid/ready handshake. Upstream operand registers drive the multiplier; this block paces them through InReady.

## Interface
- ACC_W, 12: accumulator/result width in bits, signed; legal range 8..32.
- LEN_W, 4: width of the frame-length field; frames of 0..2^LEN_W-1 products.
- Clk  input  1  single clock; all state changes on rising edge.
- Rst_n  input  1  reset; synchronous, active-low.
- Start  input  1  frame start request; sampled only in IDLE.
- FrameLen  input  LEN_W  number of products in the frame; sampled with Start.
- InValid  input  1  Product is valid this cycle.
- InReady  output  1  block accepts a product this cycle.
- Product  input  8  signed two's-complement product from the multiplier.
- OutValid  output  1  AccOut/Overflow hold a completed frame result.
- OutReady  input  1  downstream accepts the result.
- AccOut  output  ACC_W  signed frame sum, saturated.
- Overflow  output  1  sticky per frame: saturation occurred at least once.
- Busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCUM, DONE. Encoding is free.
- IDLE: InReady=0, OutValid=0. On Start=1:
  - FrameLen!=0: clear accumulator and Overflow, load remaining count = FrameLen, go ACCUM.
  - FrameLen=0: clear accumulator and Overflow, go DONE directly (result 0).
- ACCUM: InReady=1. A beat transfers when InValid&InReady. Per beat:
  - sum = acc + sign-extend(Product) computed at ACC_W+1 bits.
  - sum > 2^(ACC_W-1)-1 -> acc = max positive, Overflow=1; sum < -2^(ACC_W-1) -> acc = max negative, Overflow=1; otherwise acc = sum.
  - Saturated acc keeps accumulating from the clamped value (a later negative product may bring it back in range; Overflow stays 1).
  - count decrements; beat with count==1 is last -> go DONE.
  - InValid=0 cycles: no change (bubbles allowed, unlimited).
- DONE: OutValid=1, AccOut and Overflow stable. On OutReady=1 -> IDLE. OutValid/AccOut must not change while OutValid=1 and OutReady=0.
- Start outside IDLE is ignored (no queuing). Product is ignored outside ACCUM.
- AccOut reflects the running accumulator at all times; it is only meaningful when OutValid=1.

## Timing
- Reset (Rst_n=0 at a rising edge): state IDLE, accumulator 0, count 0, Overflow 0, InReady 0, OutValid 0, Busy 0, AccOut 0. Applies mid-frame and in DONE alike; partial sums are discarded; no output beat is produced.
- Start sampled in IDLE at edge N -> InReady=1 and Busy=1 from cycle N+1.
- Last beat accepted at edge M -> OutValid=1 from cycle M+1; InReady=0 from cycle M+1 (no product accepted after the last beat).
- FrameLen=0: Start at edge N -> OutValid=1 at cycle N+1, AccOut=0.
- OutReady at edge K in DONE -> IDLE from K+1; a Start at K+1 is accepted (minimum 1 idle cycle between frames).
- Throughput: 1 product per cycle in ACCUM; frame of L products takes L+2 cycles from Start to result handoff with zero backpressure.
- Outputs are registered; InReady, OutValid, Busy decode from state register only (no combinational input-to-output path).

## Test plan
- Reset then idle: Rst_n low 3 cycles -> all outputs 0; Start=0, InValid=1 for 5 cycles -> InReady=0, no state change.
- Basic frame: Start, FrameLen=3, products 5, -3, 10 back-to-back -> OutValid cycle after third beat, AccOut=12, Overflow=0; hold OutReady=0 for 4 cycles -> AccOut stable; OutReady=1 -> IDLE.
- Bubbles and max length: FrameLen=15, products all 64 (+8*+8? use -8*-8=64) with InValid toggling every other cycle -> AccOut=960, Overflow=0, exactly 15 beats accepted.
- Saturation with ACC_W=8: FrameLen=3, products 64, 64, -10 -> sums clamp to 127 then 117; AccOut=117, Overflow=1. Negative: products -56, -56, -56 -> AccOut=-128, Overflow=1.
- Zero-length and ignored Start: FrameLen=0 -> AccOut=0 one cycle after Start; Start pulsed during ACCUM and DONE -> no effect on count or result.
- Reset mid-frame: FrameLen=4, accept 2 beats, Rst_n=0 one cycle -> IDLE, AccOut=0, OutValid never asserted; new frame FrameLen=1, product -7 -> AccOut=-7.
